// File: rtl/spi_tx_commit_buffer_if.sv
// Bus bundle between the SPI link layer, the commit buffer and the MIL transmitter.
// The slave modport is the buffer side; the master modport is the link/transmitter side.
interface spi_tx_commit_buffer_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             pkt_start;
  logic             pkt_accept;
  logic             pkt_end;
  logic             pkt_ok;
  logic             in_request;
  logic [WIDTH-1:0] in_data;
  logic             in_done;
  logic             out_request;
  logic [WIDTH-1:0] out_data;
  logic             out_done;
  logic [CW-1:0]    committed_cnt;
  logic             overflow;
  logic             clr_overflow;

  modport slave (
    input  pkt_start, pkt_accept, pkt_end, pkt_ok, in_request, in_data,
    input  out_done, clr_overflow,
    output in_done, out_request, out_data, committed_cnt, overflow
  );

  modport master (
    output pkt_start, pkt_accept, pkt_end, pkt_ok, in_request, in_data,
    output out_done, clr_overflow,
    input  in_done, out_request, out_data, committed_cnt, overflow
  );
endinterface

// File: rtl/spi_tx_commit_buffer.sv
// Holds SPI payload words as tentative until the packet checksum is confirmed, then exposes them to the MIL side.
// Optional packet statistics counters are enabled with the SPI_TX_COMMIT_STATS_EN macro.
module spi_tx_commit_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nRst,
  spi_tx_commit_buffer_if.slave bus
`ifdef SPI_TX_COMMIT_STATS_EN
  ,
  output logic [15:0]          stat_committed,
  output logic [15:0]          stat_rejected,
  output logic [15:0]          stat_dropped
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, SKIP, DROP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_cm_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_wr_next;
  logic [PW-1:0]    w_cm_next;
  logic [PW-1:0]    w_rd_next;
  logic [PW-1:0]    w_used;
  logic [PW-1:0]    w_cnt;
  logic [PW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out_data;
  logic             r_in_done;
  logic             r_overflow;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_fire;
  logic             w_bypass;
  logic             w_ovf_set;
  logic             w_commit_evt;
  logic             w_reject_evt;
  logic             w_drop_evt;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_used == DEPTH_P);
  assign w_cnt      = r_cm_ptr - r_rd_ptr;
  assign w_rd_fire  = bus.out_done && (w_cnt != '0);
  assign w_rd_next  = r_rd_ptr + PW'(w_rd_fire);
  assign w_cnt_next = w_cm_next - w_rd_next;
  // A start pulse restarts the packet, so a word arriving with it is not stored.
  assign w_wr_en    = (r_state == COLLECT) && !bus.pkt_start && bus.in_request && !w_full;
  // Word written this cycle may be the very next one to present (commit on the same edge).
  assign w_bypass   = w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0]);

  always_comb begin
    w_state_next = r_state;
    w_wr_next    = r_wr_ptr;
    w_cm_next    = r_cm_ptr;
    w_ovf_set    = 1'b0;
    w_commit_evt = 1'b0;
    w_reject_evt = 1'b0;
    w_drop_evt   = 1'b0;
    if (bus.pkt_start) begin
      w_wr_next    = r_cm_ptr;
      w_reject_evt = (r_state == COLLECT);
      w_state_next = bus.pkt_accept ? COLLECT : SKIP;
    end else begin
      case (r_state)
        COLLECT: begin
          if (bus.in_request) begin
            if (w_full) begin
              w_state_next = DROP;
              w_ovf_set    = 1'b1;
              w_drop_evt   = 1'b1;
            end else begin
              w_wr_next = r_wr_ptr + PW'(1);
            end
          end
          if (bus.pkt_end) begin
            w_state_next = IDLE;
            if (w_ovf_set || !bus.pkt_ok) begin
              w_wr_next    = r_cm_ptr;
              w_reject_evt = !w_ovf_set;
            end else begin
              w_cm_next    = w_wr_next;
              w_commit_evt = 1'b1;
            end
          end
        end
        SKIP: begin
          if (bus.pkt_end) w_state_next = IDLE;
        end
        DROP: begin
          if (bus.pkt_end) begin
            w_wr_next    = r_cm_ptr;
            w_state_next = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_done  <= 1'b0;
      r_overflow <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_wr_ptr  <= w_wr_next;
      r_cm_ptr  <= w_cm_next;
      r_rd_ptr  <= w_rd_next;
      r_in_done <= bus.in_request;
      if (w_ovf_set)             r_overflow <= 1'b1;
      else if (bus.clr_overflow) r_overflow <= 1'b0;
      if (w_cnt_next != '0)
        r_out_data <= w_bypass ? bus.in_data : r_mem[w_rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
  end

  assign bus.in_done       = r_in_done;
  assign bus.out_request   = (w_cnt != '0);
  assign bus.out_data      = r_out_data;
  assign bus.committed_cnt = w_cnt;
  assign bus.overflow      = r_overflow;

`ifdef SPI_TX_COMMIT_STATS_EN
  logic [2:0] w_stat_evt;
  assign w_stat_evt = {w_drop_evt, w_reject_evt, w_commit_evt};

  // One saturating counter per event kind: 0 committed, 1 rejected, 2 dropped.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] r_cnt;
      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          r_cnt <= '0;
        end else if (w_stat_evt[gi]) begin
          if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end else if (bus.clr_overflow) begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

  assign stat_committed = g_stat[0].r_cnt;
  assign stat_rejected  = g_stat[1].r_cnt;
  assign stat_dropped   = g_stat[2].r_cnt;
`else
  logic w_stats_unused;
  assign w_stats_unused = w_commit_evt ^ w_reject_evt ^ w_drop_evt;
`endif
endmodule

// File: tb/tb_spi_tx_commit_buffer.sv
// Directed bench for spi_tx_commit_buffer: a DEPTH=64 instance for the main flow and a DEPTH=4
// instance sharing the same stimulus for the overflow corner cases.
module tb_spi_tx_commit_buffer;
  logic clk;
  logic nRst;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_tx_commit_buffer_if #(.DEPTH(64), .WIDTH(16)) bus ();
  spi_tx_commit_buffer_if #(.DEPTH(4),  .WIDTH(16)) bus4 ();

  assign bus4.pkt_start    = bus.pkt_start;
  assign bus4.pkt_accept   = bus.pkt_accept;
  assign bus4.pkt_end      = bus.pkt_end;
  assign bus4.pkt_ok       = bus.pkt_ok;
  assign bus4.in_request   = bus.in_request;
  assign bus4.in_data      = bus.in_data;
  assign bus4.out_done     = bus.out_done;
  assign bus4.clr_overflow = bus.clr_overflow;

`ifdef SPI_TX_COMMIT_STATS_EN
  logic [15:0] sc, sr, sd, sc4, sr4, sd4;
`endif

  spi_tx_commit_buffer #(.DEPTH(64), .WIDTH(16)) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
`ifdef SPI_TX_COMMIT_STATS_EN
    , .stat_committed(sc), .stat_rejected(sr), .stat_dropped(sd)
`endif
  );

  spi_tx_commit_buffer #(.DEPTH(4), .WIDTH(16)) dut4 (
    .clk (clk),
    .nRst(nRst),
    .bus (bus4)
`ifdef SPI_TX_COMMIT_STATS_EN
    , .stat_committed(sc4), .stat_rejected(sr4), .stat_dropped(sd4)
`endif
  );

  typedef struct {
    bit          st;
    bit          acc;
    bit          en;
    bit          ok;
    bit          rq;
    logic [15:0] d;
    bit          dn;
    bit          e_done;
    int          e_cnt;
    bit          e_oreq;
    bit          chk_od;
    logic [15:0] e_od;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit st, input bit acc, input bit en, input bit ok, input bit rq,
                      input logic [15:0] d, input bit dn, input bit clr);
    bus.pkt_start    = st;
    bus.pkt_accept   = acc;
    bus.pkt_end      = en;
    bus.pkt_ok       = ok;
    bus.in_request   = rq;
    bus.in_data      = d;
    bus.out_done     = dn;
    bus.clr_overflow = clr;
    @(posedge clk);
    #1;
    bus.pkt_start    = 1'b0;
    bus.pkt_accept   = 1'b0;
    bus.pkt_end      = 1'b0;
    bus.pkt_ok       = 1'b0;
    bus.in_request   = 1'b0;
    bus.in_data      = 16'h0;
    bus.out_done     = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  task automatic idle();                      tick(0, 0, 0, 0,  0, 16'h0, 0, 0); endtask
  task automatic begin_pkt(input bit acc);    tick(1, acc, 0, 0, 0, 16'h0, 0, 0); endtask
  task automatic end_pkt(input bit ok);       tick(0, 0, 1, ok, 0, 16'h0, 0, 0); endtask
  task automatic push(input logic [15:0] d);  tick(0, 0, 0, 0,  1, d,     0, 0); endtask
  task automatic pop();                       tick(0, 0, 0, 0,  0, 16'h0, 1, 0); endtask
  task automatic clr();                       tick(0, 0, 0, 0,  0, 16'h0, 0, 1); endtask

  task automatic do_reset();
    nRst = 1'b0;
    idle();
    idle();
    nRst = 1'b1;
    idle();
  endtask

  task automatic add(input bit st, input bit acc, input bit en, input bit ok, input bit rq,
                     input logic [15:0] d, input bit dn, input bit e_done, input int e_cnt,
                     input bit e_oreq, input bit chk_od, input logic [15:0] e_od);
    vec_t v;
    v = '{st, acc, en, ok, rq, d, dn, e_done, e_cnt, e_oreq, chk_od, e_od};
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] gw [6];
    vec_t        v;
    int          model_cnt;
    int          consumed;
    int          p;
    int          ph;
    bit          st, rq, en, dn;
    logic [15:0] d;
    logic [15:0] stage[$];
    logic [15:0] expq[$];

    gw = '{16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1};

    nRst = 1'b0;
    bus.pkt_start = 1'b0; bus.pkt_accept = 1'b0; bus.pkt_end = 1'b0; bus.pkt_ok = 1'b0;
    bus.in_request = 1'b0; bus.in_data = 16'h0; bus.out_done = 1'b0; bus.clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, held in reset and just after release
    check("rst_in_done",  bus.in_done, 0);
    check("rst_oreq",     bus.out_request, 0);
    check("rst_odata",    bus.out_data, 0);
    check("rst_cnt",      bus.committed_cnt, 0);
    check("rst_overflow", bus.overflow, 0);
    nRst = 1'b1;
    idle();
    check("post_rst_cnt",   bus.committed_cnt, 0);
    check("post_rst_odata", bus.out_data, 0);

    // Good packet, then drain
    add(1, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 1, gw[k], 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 1, 1, 0, 16'h0, 0, 0, 6, 1, 1, gw[0]);
    for (int k = 1; k < 6; k++) add(0, 0, 0, 0, 0, 16'h0, 1, 0, 6 - k, 1, 1, gw[k]);
    add(0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
    add(0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
    // Bad checksum, then a good two-word packet
    add(1, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(0, 0, 0, 0, 1, 16'h1111, 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 0, 0, 1, 16'h2222, 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 0, 0, 1, 16'h3333, 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(1, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(0, 0, 0, 0, 1, 16'h1234, 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 0, 0, 1, 16'h5678, 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 1, 1, 0, 16'h0, 0, 0, 2, 1, 1, 16'h1234);
    add(0, 0, 0, 0, 0, 16'h0, 1, 0, 1, 1, 1, 16'h5678);
    add(0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0);
    // Not accepted: words acknowledged, nothing stored
    add(1, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 16'hC001 + 16'(k), 0, 1, 0, 0, 0, 16'h0);
    add(0, 0, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    // Zero-length commit, then pkt_end while idle, then one more word
    add(1, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(0, 0, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(0, 0, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(1, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    add(0, 0, 1, 1, 1, 16'h4242, 0, 1, 1, 1, 1, 16'h4242);
    add(0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      tick(v.st, v.acc, v.en, v.ok, v.rq, v.d, v.dn, 0);
      $display("vec %0d: in_done=%0b cnt=%0d oreq=%0b odata=%h", i, bus.in_done,
               bus.committed_cnt, bus.out_request, bus.out_data);
      check($sformatf("vec%0d_in_done", i), bus.in_done, v.e_done);
      check($sformatf("vec%0d_cnt", i), bus.committed_cnt, v.e_cnt);
      check($sformatf("vec%0d_oreq", i), bus.out_request, v.e_oreq);
      if (v.chk_od) check($sformatf("vec%0d_odata", i), bus.out_data, v.e_od);
    end

    // Overflow on the DEPTH=4 instance with a committed packet ahead of it
    do_reset();
    begin_pkt(1); push(16'hAAAA); push(16'hBBBB); end_pkt(1);
    begin_pkt(1);
    for (int k = 0; k < 6; k++) begin
      push(16'h0D01 + 16'(k));
      check($sformatf("ovf_in_done%0d", k), bus4.in_done, 1);
    end
    end_pkt(1);
    $display("overflow pkt: overflow=%0b cnt=%0d", bus4.overflow, bus4.committed_cnt);
    check("ovf_flag", bus4.overflow, 1);
    check("ovf_cnt", bus4.committed_cnt, 2);
    check("ovf_odata0", bus4.out_data, 16'hAAAA);
    pop();
    check("ovf_odata1", bus4.out_data, 16'hBBBB);
    check("ovf_cnt1", bus4.committed_cnt, 1);
    pop();
    check("ovf_drained_oreq", bus4.out_request, 0);
    clr();
    check("ovf_cleared", bus4.overflow, 0);
    // Exactly full packet fits without overflow
    begin_pkt(1);
    for (int k = 0; k < 4; k++) push(16'hE001 + 16'(k));
    end_pkt(1);
    check("full_cnt", bus4.committed_cnt, 4);
    check("full_no_ovf", bus4.overflow, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full_odata%0d", k), bus4.out_data, 16'hE001 + 16'(k));
      pop();
    end
    check("full_drained", bus4.committed_cnt, 0);
    // Overflow set in the same cycle as clr_overflow keeps the flag
    begin_pkt(1);
    for (int k = 0; k < 4; k++) push(16'hF001 + 16'(k));
    tick(0, 0, 0, 0, 1, 16'hF005, 0, 1);
    check("set_wins", bus4.overflow, 1);
    end_pkt(1);
    check("set_wins_cnt", bus4.committed_cnt, 0);
    check("set_wins_oreq", bus4.out_request, 0);
    clr();
    check("set_wins_clr", bus4.overflow, 0);

    // Reset mid-packet with committed but unread words
    do_reset();
    begin_pkt(1); push(16'h5151); push(16'h5252); end_pkt(1);
    check("mid_cnt_pre", bus.committed_cnt, 2);
    begin_pkt(1); push(16'h0101); push(16'h0202);
    check("mid_in_done_pre", bus.in_done, 1);
    nRst = 1'b0;
    #2;
    $display("mid-packet reset: cnt=%0d oreq=%0b in_done=%0b", bus.committed_cnt,
             bus.out_request, bus.in_done);
    check("mid_in_done", bus.in_done, 0);
    check("mid_oreq", bus.out_request, 0);
    check("mid_cnt", bus.committed_cnt, 0);
    check("mid_odata", bus.out_data, 0);
    check("mid_overflow", bus.overflow, 0);
    idle();
    nRst = 1'b1;
    idle();
    begin_pkt(1); push(16'h7777); push(16'h8888); end_pkt(1);
    check("mid_new_cnt", bus.committed_cnt, 2);
    check("mid_new_od0", bus.out_data, 16'h7777);
    pop();
    check("mid_new_od1", bus.out_data, 16'h8888);
    pop();
    check("mid_new_done", bus.out_request, 0);

    // Advance pointers near wrap, then 10 packets against a slow reader
    do_reset();
    for (int r = 0; r < 2; r++) begin
      begin_pkt(1);
      for (int k = 0; k < 60; k++) push(16'h2000 + 16'(k));
      end_pkt(1);
      check($sformatf("fill%0d_cnt", r), bus.committed_cnt, 60);
      for (int k = 0; k < 60; k++) begin
        check($sformatf("fill%0d_od%0d", r, k), bus.out_data, 16'h2000 + 16'(k));
        pop();
      end
      check($sformatf("fill%0d_empty", r), bus.committed_cnt, 0);
    end

    model_cnt = 0;
    consumed  = 0;
    for (int c = 0; c < 200 && consumed < 30; c++) begin
      st = 0; rq = 0; en = 0; dn = 0; d = 16'h0;
      p  = c / 5;
      ph = c % 5;
      if (p < 10) begin
        if (ph == 0) st = 1;
        else if (ph <= 3) begin
          rq = 1;
          d  = 16'h3000 + 16'(p * 3 + ph - 1);
        end else en = 1;
      end
      check($sformatf("wrap_oreq_c%0d", c), bus.out_request, model_cnt != 0);
      if ((c % 2 == 0) && model_cnt > 0) begin
        dn = 1;
        check($sformatf("wrap_od_c%0d", c), bus.out_data, expq[0]);
      end
      tick(st, 1, en, 1, rq, d, dn, 0);
      if (dn) begin
        void'(expq.pop_front());
        model_cnt--;
        consumed++;
      end
      if (rq) stage.push_back(d);
      if (en) begin
        foreach (stage[k]) expq.push_back(stage[k]);
        model_cnt += stage.size();
        stage.delete();
      end
      check($sformatf("wrap_cnt_c%0d", c), bus.committed_cnt, model_cnt);
    end
    $display("wrap run: %0d words drained", consumed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
